// File: rtl/rf_snap.sv
// Parametrised two-read/one-write register file with write-before-read bypass
// and a single-level shadow snapshot for save/restore context checkpointing.
module rf_snap #(
  parameter int WIDTH = 32'd16,
  parameter int NREGS = 32'd8,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  input  logic [SELW-1:0]  writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             snap_valid,
  output logic             err
);

  logic [WIDTH-1:0] live_r   [NREGS];
  logic [WIDTH-1:0] shadow_r [NREGS];
  logic             snap_valid_r;

  logic             save_ok_s;
  logic             restore_ok_s;
  logic             err_s;
  logic [WIDTH-1:0] read1_s;
  logic [WIDTH-1:0] read2_s;

  // Legal save/restore qualification and the illegal-request flag.
  always_comb begin
    save_ok_s    = save & ~restore;
    restore_ok_s = restore & ~save & snap_valid_r;
    err_s        = 1'b0;
    if (rst) begin
      err_s = 1'b0;
    end else begin
      err_s = (save & restore) | (restore & ~snap_valid_r);
    end
  end

  // Live array, shadow bank and snapshot flag; a write beats restore per register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        live_r[i]   <= '0;
        shadow_r[i] <= '0;
      end
      snap_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (write && (writeregsel == SELW'(i))) begin
          live_r[i] <= writedata;
        end else if (restore_ok_s) begin
          live_r[i] <= shadow_r[i];
        end
      end
      if (save_ok_s) begin
        shadow_r     <= live_r;
        snap_valid_r <= 1'b1;
      end
    end
  end

  // Read ports with bypass; an unknown select propagates X through the compare and index.
  always_comb begin
    read1_s = live_r[read1regsel];
    read2_s = live_r[read2regsel];
    if (write && (read1regsel == writeregsel)) begin
      read1_s = writedata;
    end else begin
      read1_s = live_r[read1regsel];
    end
    if (write && (read2regsel == writeregsel)) begin
      read2_s = writedata;
    end else begin
      read2_s = live_r[read2regsel];
    end
  end

  assign read1data  = read1_s;
  assign read2data  = read2_s;
  assign snap_valid = snap_valid_r;
  assign err        = err_s;

endmodule

// File: tb/tb_rf_snap.sv
// Scoreboard-driven bench for rf_snap: default 16x8 instance plus a 32x16 instance.
module tb_rf_snap;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, write, save, restore;
  logic [2:0]  r1, r2, ws;
  logic [15:0] wd;
  logic [15:0] rd1, rd2;
  logic        sv, er;

  logic        brst, bwrite, bsave, brestore;
  logic [3:0]  br1, br2, bws;
  logic [31:0] bwd;
  logic [31:0] brd1, brd2;
  logic        bsv, ber;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  rf_snap dut (
    .clk(clk), .rst(rst), .read1regsel(r1), .read2regsel(r2), .writeregsel(ws),
    .writedata(wd), .write(write), .save(save), .restore(restore),
    .read1data(rd1), .read2data(rd2), .snap_valid(sv), .err(er)
  );

  rf_snap #(.WIDTH(32), .NREGS(16)) dut_big (
    .clk(clk), .rst(brst), .read1regsel(br1), .read2regsel(br2), .writeregsel(bws),
    .writedata(bwd), .write(bwrite), .save(bsave), .restore(brestore),
    .read1data(brd1), .read2data(brd2), .snap_valid(bsv), .err(ber)
  );

  task automatic idle();
    write = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b1; ws = 3'd3; wd = 16'hFFFF; save = 1'b1; restore = 1'b1;
    r1 = 3'd3; r2 = 3'd0;
    exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (er !== e[0]) begin n_err++; $display("FAIL err_during_rst: got %b want %b", er, e[0]); end
    next(); next();
    rst = 1'b0; idle();
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i); r2 = 3'(7 - i);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (rd1 !== e[15:0]) begin n_err++; $display("FAIL reset_rd1 R%0d: got %h want %h", r1, rd1, e[15:0]); end
      e = exp_q.pop_front(); n_vec++;
      if (rd2 !== e[15:0]) begin n_err++; $display("FAIL reset_rd2 R%0d: got %h want %h", r2, rd2, e[15:0]); end
      e = exp_q.pop_front(); n_vec++;
      if (sv !== e[0]) begin n_err++; $display("FAIL reset_snap_valid: got %b want %b", sv, e[0]); end
      e = exp_q.pop_front(); n_vec++;
      if (er !== e[0]) begin n_err++; $display("FAIL reset_err: got %b want %b", er, e[0]); end
      next();
    end
  endtask

  task automatic test_write_bypass();
    // R3 bypass on both ports, then register 0 bypass (no hardwired zero)
    write = 1'b1; ws = 3'd3; wd = 16'hBEEF; r1 = 3'd3; r2 = 3'd3;
    exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL bypass_rd1: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL bypass_rd2: got %h want %h", rd2, e[15:0]); end
    next();
    ws = 3'd0; wd = 16'h00A0; r1 = 3'd0; r2 = 3'd3;
    exp_q.push_back(32'h00A0); exp_q.push_back(32'hBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL bypass_r0: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL stored_r3: got %h want %h", rd2, e[15:0]); end
    next();
    idle(); r1 = 3'd0; r2 = 3'd4;
    exp_q.push_back(32'h00A0); exp_q.push_back(32'h0000);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL stored_r0: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL untouched_r4: got %h want %h", rd2, e[15:0]); end
    next();
  endtask

  task automatic test_save_restore();
    write = 1'b1; ws = 3'd1; wd = 16'h1111; next();
    ws = 3'd2; wd = 16'h2222; next();
    // save with a same-cycle write to R6: the write must not reach the shadow
    save = 1'b1; ws = 3'd6; wd = 16'h6666; next();
    save = 1'b0; ws = 3'd1; wd = 16'hAAAA;
    exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (sv !== e[0]) begin n_err++; $display("FAIL snap_valid_after_save: got %b want %b", sv, e[0]); end
    next();
    idle(); restore = 1'b1; r1 = 3'd1; r2 = 3'd6;
    exp_q.push_back(32'hAAAA); exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL pre_restore_r1: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (er !== e[0]) begin n_err++; $display("FAIL restore_err: got %b want %b", er, e[0]); end
    next();
    idle(); r1 = 3'd1; r2 = 3'd2;
    exp_q.push_back(32'h1111); exp_q.push_back(32'h2222); exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL restored_r1: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL restored_r2: got %h want %h", rd2, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (sv !== e[0]) begin n_err++; $display("FAIL snap_valid_kept: got %b want %b", sv, e[0]); end
    r1 = 3'd6;
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL restored_r6: got %h want %h", rd1, e[15:0]); end
  endtask

  task automatic test_back_to_back();
    write = 1'b1; ws = 3'd5; wd = 16'h0505; next();
    // save with a write to R1 that the snapshot must not hold, then restore at once
    save = 1'b1; ws = 3'd1; wd = 16'h9999; next();
    save = 1'b0; restore = 1'b1; ws = 3'd2; wd = 16'h5555; r1 = 3'd2; r2 = 3'd1;
    exp_q.push_back(32'h5555); exp_q.push_back(32'h9999);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL restore_bypass_r2: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL restore_cycle_r1: got %h want %h", rd2, e[15:0]); end
    next();
    idle(); r1 = 3'd2; r2 = 3'd5;
    exp_q.push_back(32'h5555); exp_q.push_back(32'h0505);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL write_over_restore_r2: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL restored_r5: got %h want %h", rd2, e[15:0]); end
    r1 = 3'd1;
    exp_q.push_back(32'h1111);
    @(posedge clk); #1;
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL b2b_restored_r1: got %h want %h", rd1, e[15:0]); end
  endtask

  task automatic test_err();
    rst = 1'b1; idle(); next();
    rst = 1'b0; write = 1'b1; ws = 3'd3; wd = 16'h0033; next();
    idle(); restore = 1'b1; r1 = 3'd3;
    exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (er !== e[0]) begin n_err++; $display("FAIL err_restore_no_snap: got %b want %b", er, e[0]); end
    next();
    restore = 1'b1; save = 1'b1; write = 1'b1; ws = 3'd4; wd = 16'h0044; r1 = 3'd3; r2 = 3'd1;
    exp_q.push_back(32'h0033); exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL r3_unchanged: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (er !== e[0]) begin n_err++; $display("FAIL err_save_and_restore: got %b want %b", er, e[0]); end
    next();
    idle(); r1 = 3'd4; r2 = 3'd1;
    exp_q.push_back(32'h0044); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd1 !== e[15:0]) begin n_err++; $display("FAIL err_write_r4: got %h want %h", rd1, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (rd2 !== e[15:0]) begin n_err++; $display("FAIL r1_after_rst: got %h want %h", rd2, e[15:0]); end
    e = exp_q.pop_front(); n_vec++;
    if (sv !== e[0]) begin n_err++; $display("FAIL snap_valid_stays_0: got %b want %b", sv, e[0]); end
    e = exp_q.pop_front(); n_vec++;
    if (er !== e[0]) begin n_err++; $display("FAIL err_idle: got %b want %b", er, e[0]); end
    next();
  endtask

  task automatic test_wide();
    brst = 1'b0; bwrite = 1'b1; bws = 4'd15; bwd = 32'hDEADBEEF; br1 = 4'd15; br2 = 4'd0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (brd1 !== e) begin n_err++; $display("FAIL wide_bypass_r15: got %h want %h", brd1, e); end
    next();
    bwrite = 1'b0; bsave = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (brd1 !== e) begin n_err++; $display("FAIL wide_stored_r15: got %h want %h", brd1, e); end
    next();
    bsave = 1'b0; brst = 1'b1;
    exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (bsv !== e[0]) begin n_err++; $display("FAIL wide_snap_valid: got %b want %b", bsv, e[0]); end
    next();
    brst = 1'b0; brestore = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (ber !== e[0]) begin n_err++; $display("FAIL wide_err_after_rst: got %b want %b", ber, e[0]); end
    e = exp_q.pop_front(); n_vec++;
    if (brd1 !== e) begin n_err++; $display("FAIL wide_r15_cleared: got %h want %h", brd1, e); end
    next();
    brestore = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (brd1 !== e) begin n_err++; $display("FAIL wide_r15_no_restore: got %h want %h", brd1, e); end
    e = exp_q.pop_front(); n_vec++;
    if (bsv !== e[0]) begin n_err++; $display("FAIL wide_snap_valid_cleared: got %b want %b", bsv, e[0]); end
    next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; write = 1'b0; save = 1'b0; restore = 1'b0;
    r1 = 3'd0; r2 = 3'd0; ws = 3'd0; wd = 16'h0000;
    brst = 1'b1; bwrite = 1'b0; bsave = 1'b0; brestore = 1'b0;
    br1 = 4'd0; br2 = 4'd0; bws = 4'd0; bwd = 32'h0;
    test_reset();
    test_write_bypass();
    test_save_restore();
    test_back_to_back();
    test_err();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
